// File: rtl/multiword_adder_sequencer.sv
// Word-serial wide adder/subtractor: one 16-bit ripple-carry adder is reused for every word,
// least-significant word first, with the inter-word carry held in a register.
module multiword_adder_sequencer #(
    parameter int unsigned WORDS = 4,
    localparam int unsigned WIDTH = 16 * WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned IdxW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             busy_q;
    logic             done_q;
    logic             c_out_q;
    logic             overflow_q;

    logic [15:0] word_a;
    logic [15:0] word_b;
    logic [15:0] add_sum;
    logic        add_cy;
    logic        rc;
    logic        last_word;

    assign last_word = (idx_q == IdxW'(WORDS - 1));

    // Word select feeding the shared adder.
    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IdxW'(w)) begin
                word_a = a_q[16*w +: 16];
                word_b = b_q[16*w +: 16];
            end
        end
    end

    // The shared 16-bit ripple-carry adder.
    always_comb begin
        add_sum = '0;
        rc      = carry_q;
        for (int i = 0; i < 16; i++) begin
            add_sum[i] = word_a[i] ^ word_b[i] ^ rc;
            rc         = (word_a[i] & word_b[i]) | (rc & (word_a[i] ^ word_b[i]));
        end
        add_cy = rc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StFin: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; the inverted operand is stored.
                        state_q    <= StRun;
                        idx_q      <= '0;
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        carry_q    <= sub | c_in;
                        busy_q     <= 1'b1;
                        c_out_q    <= 1'b0;
                        overflow_q <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx_q == IdxW'(w)) begin
                            sum_q[16*w +: 16] <= add_sum;
                        end
                    end
                    carry_q <= add_cy;
                    idx_q   <= idx_q + 1'b1;
                    if (last_word) begin
                        state_q    <= StFin;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        c_out_q    <= add_cy;
                        overflow_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                      (add_sum[15] != a_q[WIDTH-1]);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Self-checking bench: directed table, reset/back-to-back sequences and random operands
// compared against plain full-width arithmetic.
module tb_multiword_adder_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, sub, c_in;
    logic [63:0] a, b;
    logic        busy, done, c_out, ovf;
    logic [63:0] sum;

    logic        start2, sub2, cin2;
    logic [31:0] a2, b2;
    logic        busy2, done2, c_out2, ovf2;
    logic [31:0] sum2;

    multiword_adder_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .c_in(c_in), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(ovf)
    );

    multiword_adder_sequencer #(.WORDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .c_in(cin2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(c_out2), .overflow(ovf2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: returns {overflow, c_out, sum} using whole-number arithmetic.
    function automatic logic [65:0] model64(input logic [63:0] x, input logic [63:0] y,
                                            input logic ci, input logic s);
        logic [64:0] full;
        logic        v;
        if (s) begin
            full = {1'b0, x} + {1'b0, ~y} + 65'd1;
            v    = (x[63] != y[63]) && (full[63] != x[63]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            v    = (x[63] == y[63]) && (full[63] != x[63]);
        end
        return {v, full};
    endfunction

    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic s);
        logic [32:0] full;
        logic        v;
        if (s) begin
            full = {1'b0, x} + {1'b0, ~y} + 33'd1;
            v    = (x[31] != y[31]) && (full[31] != x[31]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            v    = (x[31] == y[31]) && (full[31] != x[31]);
        end
        return {v, full};
    endfunction

    task automatic run4(input string nm, input logic [63:0] ia, input logic [63:0] ib,
                        input logic ici, input logic isub, input logic [63:0] es,
                        input logic ec, input logic eo);
        int n;
        bit got;
        @(negedge clk);
        a = ia; b = ib; c_in = ici; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        chk({nm, " busy@accept"}, 64'(busy), 64'd1);
        chk({nm, " cout cleared"}, 64'({c_out, ovf}), 64'd0);
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        sub = 1'($urandom); c_in = 1'($urandom);
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            chk({nm, " done timeout"}, 64'd0, 64'd1);
        end else begin
            chk({nm, " latency"}, 64'(n), 64'd4);
            chk({nm, " busy@done"}, 64'(busy), 64'd0);
            chk({nm, " sum"}, sum, es);
            chk({nm, " c_out"}, 64'(c_out), 64'(ec));
            chk({nm, " overflow"}, 64'(ovf), 64'(eo));
            @(posedge clk); #1;
            chk({nm, " done pulse"}, 64'(done), 64'd0);
            chk({nm, " sum hold"}, sum, es);
        end
    endtask

    task automatic run2(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ici, input logic isub);
        int n;
        bit got;
        logic [33:0] m;
        m = model32(ia, ib, ici, isub);
        @(negedge clk);
        a2 = ia; b2 = ib; cin2 = ici; sub2 = isub; start2 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start2 = 1'b0; a2 = $urandom; b2 = $urandom;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done2) got = 1'b1;
        end
        if (!got) begin
            chk({nm, " done timeout"}, 64'd0, 64'd1);
        end else begin
            chk({nm, " latency"}, 64'(n), 64'd2);
            chk({nm, " sum"}, 64'(sum2), 64'(m[31:0]));
            chk({nm, " c_out"}, 64'(c_out2), 64'(m[32]));
            chk({nm, " overflow"}, 64'(ovf2), 64'(m[33]));
        end
    endtask

    typedef struct {
        string       nm;
        logic [63:0] va, vb;
        logic        ci, s;
        logic [63:0] es;
        logic        ec, eo;
    } vec_t;

    vec_t vecs[5];

    logic [63:0] oa[11], ob[11];
    logic        os[11], oc[11];

    initial begin
        vecs[0] = '{"ripple", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{"wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                    64'd0, 1'b1, 1'b0};
        vecs[2] = '{"sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{"add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;

        // Reset held 2 cycles with a start pending: reset must win.
        @(negedge clk);
        start = 1'b1; a = '1; b = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst outputs", {busy, done, c_out, ovf}, 64'd0);
        chk("rst sum", sum, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("start after rst busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid rst outputs", {busy, done, c_out, ovf}, 64'd0);
        chk("mid rst sum", sum, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            repeat (8) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            chk("no done after abort", 64'(seen), 64'd0);
        end

        for (int i = 0; i < 5; i++)
            run4(vecs[i].nm, vecs[i].va, vecs[i].vb, vecs[i].ci, vecs[i].s,
                 vecs[i].es, vecs[i].ec, vecs[i].eo);

        // Start held high with new operands every cycle: only done-cycle starts are taken.
        for (int i = 0; i < 11; i++) begin
            oa[i] = {$urandom, $urandom}; ob[i] = {$urandom, $urandom};
            os[i] = 1'($urandom); oc[i] = 1'($urandom);
        end
        begin
            int k = 0;
            int exp_edge[3] = '{4, 9, 14};
            int exp_op[3]   = '{0, 5, 10};
            logic [65:0] m;
            for (int e = 0; e < 18; e++) begin
                @(negedge clk);
                if (e <= 10) begin
                    start = 1'b1; a = oa[e]; b = ob[e]; sub = os[e]; c_in = oc[e];
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                if (busy && done) chk("b2b busy&done", 64'd1, 64'd0);
                if (done) begin
                    if (k < 3) begin
                        m = model64(oa[exp_op[k]], ob[exp_op[k]], oc[exp_op[k]], os[exp_op[k]]);
                        chk("b2b done edge", 64'(e), 64'(exp_edge[k]));
                        chk("b2b sum", sum, m[63:0]);
                        chk("b2b flags", 64'({ovf, c_out}), 64'(m[65:64]));
                    end
                    k++;
                end
            end
            start = 1'b0;
            chk("b2b result count", 64'(k), 64'd3);
        end

        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            logic        rc, rs;
            logic [65:0] m;
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            if (i % 8 == 3) ra = 64'h7FFF_FFFF_FFFF_FFFF;
            if (i % 8 == 5) rb = 64'h8000_0000_0000_0000;
            rc = 1'($urandom); rs = 1'($urandom);
            m = model64(ra, rb, rc, rs);
            run4($sformatf("rand%0d", i), ra, rb, rc, rs, m[63:0], m[64], m[65]);
        end

        run2("w2 ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        chk("w2 ovf sum const", 64'(sum2), 64'h8000_0000);
        for (int i = 0; i < 6; i++)
            run2($sformatf("w2 rand%0d", i), $urandom, $urandom, 1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
